// File: rtl/npc_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_lsu_pkg
// Description : Shared encodings for the load/store unit: FSM states, func3
//               load/store codes, error codes and op-legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_lsu_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // func3 encodings (stores reuse the low three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // out_err codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Stores only have b/h/w; loads additionally have the unsigned b/h forms.
  function automatic logic op_legal(input logic [2:0] op, input logic is_store);
    if (is_store) return (op == F3_B) || (op == F3_H) || (op == F3_W);
    return (op == F3_B) || (op == F3_H) || (op == F3_W) || (op == F3_BU) || (op == F3_HU);
  endfunction

  // Access size comes from op[1:0]; only meaningful for legal ops.
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for the LSU: store strobes and replicated
//               store data, plus extraction/extension of load data.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] w_shift;

  assign w_shift = rdata >> {offset, 3'b000};

  // Lane selection by access size; op[2] marks the zero-extending loads.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = 32'd0;
    load_data = 32'd0;
    case (mem_op[1:0])
      2'b00: begin
        wstrb     = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        load_data = mem_op[2] ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        wstrb     = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        load_data = mem_op[2] ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        load_data = w_shift;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/npc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : npc_lsu
// Description : Load/store unit. Turns one RV32I load/store into a single
//               word-aligned valid/ready bus beat, with response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mem_op,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_wen,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata
);

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_load_data;

  lsu_align u_align (
    .mem_op    (op_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (resp_rdata),
    .wstrb     (w_wstrb),
    .wdata_rep (w_wdata_rep),
    .load_data (w_load_data)
  );

  // State, request latch, timeout counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wen_q   <= 1'b0;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath: decode at accept, run the bus beat, format result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = mem_op;
          addr_d  = addr;
          wdata_d = wdata;
          wen_d   = mem_wen;
          rdata_d = 32'd0;
          err_d   = ERR_OK;
          state_d = ST_DONE;
          // Illegal ops are rejected before alignment is judged.
          if (mem_wen || mem_ren) begin
            if (!op_legal(mem_op, mem_wen))              err_d   = ERR_ILLEGAL;
            else if (op_misaligned(mem_op, addr[1:0]))   err_d   = ERR_MISALIGN;
            else                                         state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d = ST_RESP;
          cnt_d   = 32'd0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 32'd1;
        // A response in the expiry cycle still counts as a response.
        if (resp_valid) begin
          state_d = ST_DONE;
          rdata_d = wen_q ? 32'd0 : w_load_data;
          err_d   = ERR_OK;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = ST_DONE;
          rdata_d = 32'd0;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          err_d   = ERR_OK;
          cnt_d   = 32'd0;
        end
      end
    endcase
  end

  // Handshake and bus outputs decoded from the current state.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    req_valid  = (state_q == ST_REQ);
    resp_ready = (state_q == ST_RESP);
    out_valid  = (state_q == ST_DONE);
    req_addr   = req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    req_wen    = req_valid & wen_q;
    req_wdata  = (req_valid & wen_q) ? w_wdata_rep : 32'd0;
    req_wstrb  = (req_valid & wen_q) ? w_wstrb : 4'b0000;
    out_rdata  = rdata_q;
    out_err    = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_npc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_npc_lsu
// Description : Self-checking bench for npc_lsu: directed cases followed by
//               randomized transactions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  mem_op;
  logic        mem_wen, mem_ren;
  logic [31:0] addr, wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;

  int tests = 0;
  int fails = 0;

  npc_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the LSU should do for one request, from the ISA rules.
  function automatic void model(input logic [2:0] op, input logic wen, input logic ren,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int delay,
                                output logic bus, output logic [1:0] err,
                                output logic [31:0] rdata, output logic [3:0] strb,
                                output logic [31:0] rwd);
    int sz, off;
    logic [31:0] v, m;
    logic legal;
    bus = 1'b0; err = 2'd0; rdata = 32'd0; strb = 4'd0; rwd = 32'd0;
    off = int'(a[1:0]);
    if (!wen && !ren) return;
    legal = wen ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin err = 2'd2; return; end
    sz = 1 << int'(op[1:0]);
    if ((off % sz) != 0) begin err = 2'd1; return; end
    bus = 1'b1;
    if (wen) begin
      strb = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) rwd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    if (delay >= TO) begin err = 2'd3; return; end
    if (!wen) begin
      v = rd >> (8 * off);
      if (sz < 4) begin
        m = (32'd1 << (8 * sz)) - 32'd1;
        v = v & m;
        if (!op[2] && v[8*sz-1]) v = v | ~m;
      end
      rdata = v;
    end
  endfunction

  // One request, driven from a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_txn(input logic [2:0] op, input logic wen, input logic ren,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int req_stall, input int delay, input int out_stall);
    logic bus; logic [1:0] e_err; logic [31:0] e_rd; logic [3:0] e_strb; logic [31:0] e_wd;
    model(op, wen, ren, a, wd, rd, delay, bus, e_err, e_rd, e_strb, e_wd);
    in_valid = 1'b1; mem_op = op; mem_wen = wen; mem_ren = ren; addr = a; wdata = wd;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; addr = $urandom; wdata = $urandom;
    if (bus) begin
      for (int s = 0; s <= req_stall; s++) begin
        req_ready = (s == req_stall);
        check("req_valid", 32'(req_valid), 32'd1);
        check("req_addr", req_addr, {a[31:2], 2'b00});
        check("req_wen", 32'(req_wen), 32'(wen));
        check("req_wdata", req_wdata, e_wd);
        check("req_wstrb", 32'(req_wstrb), 32'(e_strb));
        check("out_valid_busy", 32'(out_valid), 32'd0);
        @(negedge clk);
      end
      req_ready = 1'b0;
      for (int k = 0; k < ((delay < TO) ? delay : TO); k++) begin
        check("resp_ready_wait", 32'(resp_ready), 32'd1);
        check("req_valid_resp", 32'(req_valid), 32'd0);
        @(negedge clk);
      end
      if (delay < TO) begin
        resp_valid = 1'b1; resp_rdata = rd;
        check("resp_ready", 32'(resp_ready), 32'd1);
        @(negedge clk);
        resp_valid = 1'b0; resp_rdata = $urandom;
      end
    end else begin
      check("req_valid_nobus", 32'(req_valid), 32'd0);
    end
    for (int s = 0; s <= out_stall; s++) begin
      out_ready = (s == out_stall);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_rdata", out_rdata, e_rd);
      check("out_err", 32'(out_err), 32'(e_err));
      check("in_ready_done", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_clr", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_op = 3'd0; mem_wen = 1'b0; mem_ren = 1'b0;
    addr = 32'd0; wdata = 32'd0; out_ready = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_resp_ready", 32'(resp_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_req_addr", req_addr, 32'd0);
    check("rst_req_wstrb", 32'(req_wstrb), 32'd0);

    // Directed cases
    run_txn(3'b010, 1, 0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);   // sw zero-wait
    run_txn(3'b000, 1, 0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);   // sb lane 3
    run_txn(3'b001, 1, 0, 32'h8000_0002, 32'h1234_5678, 32'h0, 0, 1, 0);   // sh lane 2
    run_txn(3'b000, 0, 1, 32'h8000_0002, 32'h0, 32'h0080_FF00, 0, 0, 0);   // lb
    run_txn(3'b100, 0, 1, 32'h8000_0002, 32'h0, 32'h0080_FF00, 0, 0, 0);   // lbu
    run_txn(3'b001, 0, 1, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 2, 0);   // lh
    run_txn(3'b101, 0, 1, 32'h8000_0000, 32'h0, 32'h0000_F00F, 0, 0, 0);   // lhu
    run_txn(3'b001, 0, 1, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);           // lh misaligned
    run_txn(3'b010, 1, 0, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0);           // sw misaligned
    run_txn(3'b010, 0, 1, 32'h8000_0000, 32'h0, 32'h0, 0, 10, 0);          // lw timeout
    run_txn(3'b010, 0, 1, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 3, 0);   // response at expiry
    run_txn(3'b010, 1, 0, 32'h8000_0010, 32'h0BAD_F00D, 32'h0, 3, 0, 2);   // stalls
    run_txn(3'b011, 0, 1, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);           // illegal load
    run_txn(3'b100, 1, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);           // illegal store
    run_txn(3'b010, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1);           // not a memory op
    run_txn(3'b101, 1, 1, 32'h8000_0001, 32'h0000_00FF, 32'h0, 0, 0, 0);   // both set: store wins

    // Reset pulse while waiting for a response
    in_valid = 1'b1; mem_op = 3'b010; mem_wen = 1'b0; mem_ren = 1'b1; addr = 32'h8000_0020;
    @(negedge clk);
    in_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("mid_resp_ready", 32'(resp_ready), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_resp_ready", 32'(resp_ready), 32'd0);
    check("mid_rst_req_valid", 32'(req_valid), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_rdata", out_rdata, 32'd0);
    check("mid_rst_out_err", 32'(out_err), 32'd0);
    check("mid_rst_req_addr", req_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(3'b100, 0, 1, 32'h8000_0021, 32'h0, 32'h0000_9900, 0, 0, 0);

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic w, r;
      logic [31:0] ra;
      sel = $urandom_range(0, 9);
      w = (sel >= 5);
      r = (sel >= 1 && sel <= 4) || (sel == 9);
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_txn(3'($urandom_range(0, 7)), w, r, ra, $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
